// File: rtl/execute_mc.sv
// execute_mc: multi-cycle Beta execute stage.
// Holds one instruction behind valid/ready handshakes, computes ALU results from the held
// operands, iterates MUL/MULC over W/MUL_BITS cycles, substitutes an exception instruction
// for illegal opcodes and a NOP for flushed occupants.
module execute_mc #(
    parameter int unsigned W        = 32,
    parameter int unsigned MUL_BITS = 1,
    parameter logic [31:0] NOP_INST = 32'h83FFF800,
    parameter logic [31:0] EXC_INST = 32'h77DF0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_pc,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_d,
    input  logic [31:0]  in_ir,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_pc,
    output logic [W-1:0] out_y,
    output logic [W-1:0] out_d,
    output logic [31:0]  out_ir,
    output logic         op_ld_or_ldr,
    output logic         op_st,
    output logic         op_br_or_jmp,
    output logic         busy
);
    localparam int unsigned Iters = W / MUL_BITS;
    localparam int unsigned CntW  = $clog2(Iters + 1);
    localparam int unsigned ShW   = $clog2(W);

    typedef enum logic [1:0] {StEmpty, StFull, StMul} state_e;
    typedef enum logic [3:0] {
        ClsAdd, ClsSub, ClsMul, ClsEq, ClsLt, ClsLe, ClsAnd, ClsOr,
        ClsXor, ClsXnor, ClsShl, ClsShr, ClsSra, ClsLdr, ClsZero, ClsIll
    } cls_e;

    state_e state_q, state_d;
    logic [W-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, d_q, d_d, acc_q, acc_d;
    logic [31:0] ir_q, ir_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic accept, depart, in_is_mul;
    logic [5:0] op;
    cls_e cls;
    logic [W-1:0] alu_y, mul_step;
    logic [ShW-1:0] shamt;
    logic raw_ld, raw_st, raw_br;

    assign in_ready  = !rst && (state_q == StEmpty || (state_q == StFull && out_ready));
    assign accept    = in_valid && in_ready;
    assign depart    = (state_q == StFull) && out_ready;
    // Bit 4 selects the constant variant, so MUL and MULC share this pattern.
    assign in_is_mul = in_ir[31] && !in_ir[29] && (in_ir[28:26] == 3'b010);
    assign op        = ir_q[31:26];
    assign shamt     = b_q[ShW-1:0];
    assign mul_step  = a_q * W'(b_q[MUL_BITS-1:0]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StEmpty;
        else     state_q <= state_d;
    end

    // Next-state logic; an accept always wins, flush aborts an in-progress MUL
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = in_is_mul ? StMul : StFull;
        end else begin
            case (state_q)
                StFull:  if (out_ready) state_d = StEmpty;
                StMul:   if (flush || cnt_q == CntW'(1)) state_d = StFull;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath next-state: capture, flush kill, or one multiplier iteration
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        a_d   = a_q;
        b_d   = b_q;
        d_d   = d_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (accept) begin
            pc_d  = in_pc;
            ir_d  = in_ir;
            a_d   = in_a;
            b_d   = in_b;
            d_d   = in_d;
            acc_d = '0;
            cnt_d = CntW'(Iters);
        end else if (flush && state_q != StEmpty && !depart) begin
            // Zeroed operands make the substituted NOP (an ADD) produce 0.
            ir_d  = NOP_INST;
            a_d   = '0;
            b_d   = '0;
            acc_d = '0;
            cnt_d = '0;
        end else if (state_q == StMul) begin
            acc_d = acc_q + mul_step;
            a_d   = a_q << MUL_BITS;
            b_d   = b_q >> MUL_BITS;
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '0;
            ir_q  <= NOP_INST;
            a_q   <= '0;
            b_q   <= '0;
            d_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            a_q   <= a_d;
            b_q   <= b_d;
            d_q   <= d_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    // Opcode decode of the held instruction into a result class
    always_comb begin
        cls = ClsIll;
        if (op[5]) begin
            case ({op[3], op[2:0]})
                4'b0000: cls = ClsAdd;
                4'b0001: cls = ClsSub;
                4'b0010: cls = ClsMul;
                4'b0100: cls = ClsEq;
                4'b0101: cls = ClsLt;
                4'b0110: cls = ClsLe;
                4'b1000: cls = ClsAnd;
                4'b1001: cls = ClsOr;
                4'b1010: cls = ClsXor;
                4'b1011: cls = ClsXnor;
                4'b1100: cls = ClsShl;
                4'b1101: cls = ClsShr;
                4'b1110: cls = ClsSra;
                default: cls = ClsIll;
            endcase
        end else if (op[4]) begin
            case (op[3:0])
                4'b1000, 4'b1001:          cls = ClsAdd;
                4'b1011, 4'b1100, 4'b1101: cls = ClsZero;
                4'b1111:                   cls = ClsLdr;
                default:                   cls = ClsIll;
            endcase
        end
    end

    // ALU result by class
    always_comb begin
        alu_y = '0;
        case (cls)
            ClsAdd:  alu_y = a_q + b_q;
            ClsSub:  alu_y = a_q - b_q;
            ClsMul:  alu_y = acc_q;
            ClsEq:   alu_y = W'(a_q == b_q);
            ClsLt:   alu_y = W'($signed(a_q) < $signed(b_q));
            ClsLe:   alu_y = W'($signed(a_q) <= $signed(b_q));
            ClsAnd:  alu_y = a_q & b_q;
            ClsOr:   alu_y = a_q | b_q;
            ClsXor:  alu_y = a_q ^ b_q;
            ClsXnor: alu_y = ~(a_q ^ b_q);
            ClsShl:  alu_y = a_q << shamt;
            ClsShr:  alu_y = a_q >> shamt;
            ClsSra:  alu_y = $unsigned($signed(a_q) >>> shamt);
            ClsLdr:  alu_y = b_q;
            default: alu_y = '0;
        endcase
    end

    assign raw_ld = (op == 6'b011000) || (op == 6'b011111);
    assign raw_st = (op == 6'b011001);
    assign raw_br = (op == 6'b011011) || (op == 6'b011100) || (op == 6'b011101);

    // Outputs: flush substitution beats exception substitution beats the held result
    always_comb begin
        out_valid    = (state_q == StFull);
        busy         = (state_q == StMul);
        out_pc       = pc_q;
        out_d        = d_q;
        out_ir       = ir_q;
        out_y        = alu_y;
        op_ld_or_ldr = out_valid && raw_ld;
        op_st        = out_valid && raw_st;
        op_br_or_jmp = out_valid && raw_br;
        if (flush && state_q != StEmpty) begin
            out_ir       = NOP_INST;
            out_y        = '0;
            op_ld_or_ldr = 1'b0;
            op_st        = 1'b0;
            op_br_or_jmp = 1'b0;
        end else if (cls == ClsIll) begin
            out_ir       = EXC_INST;
            out_y        = pc_q;
            op_ld_or_ldr = 1'b0;
            op_st        = 1'b0;
            op_br_or_jmp = 1'b0;
        end
    end
endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc: reset, ALU classes, backpressure, iterative MUL at two
// iteration widths, illegal-opcode substitution, flush, and a back-to-back stream.
module tb_execute_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_valid4 = 1'b0;
    logic        out_ready = 1'b0, out_ready4 = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] in_pc = '0, in_a = '0, in_b = '0, in_d = '0, in_ir = '0;

    logic        in_ready, out_valid, op_ld_or_ldr, op_st, op_br_or_jmp, busy;
    logic [31:0] out_pc, out_y, out_d, out_ir;
    logic        in_ready4, out_valid4, ld4, st4, br4, busy4;
    logic [31:0] out_pc4, out_y4, out_d4, out_ir4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_mc #(.W(32), .MUL_BITS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_ir(in_ir),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_y(out_y), .out_d(out_d), .out_ir(out_ir),
        .op_ld_or_ldr(op_ld_or_ldr), .op_st(op_st), .op_br_or_jmp(op_br_or_jmp),
        .busy(busy)
    );

    execute_mc #(.W(32), .MUL_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_pc(in_pc), .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_ir(in_ir),
        .flush(1'b0), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_pc(out_pc4), .out_y(out_y4), .out_d(out_d4), .out_ir(out_ir4),
        .op_ld_or_ldr(ld4), .op_st(st4), .op_br_or_jmp(br4),
        .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input logic [5:0] op);
        return {op, 26'h0123456};
    endfunction

    logic [5:0]  tab_op [6] = '{6'b100001, 6'b100101, 6'b100100, 6'b100110, 6'b011111,
                                6'b011011};
    logic [31:0] tab_a  [6] = '{32'd3, 32'hFFFFFFFF, 32'd4, 32'd2, 32'd9, 32'd8};
    logic [31:0] tab_b  [6] = '{32'd5, 32'd1, 32'd4, 32'd1, 32'h44, 32'd8};
    logic [31:0] tab_y  [6] = '{32'hFFFFFFFE, 32'd1, 32'd1, 32'd0, 32'h44, 32'd0};

    logic [5:0]  st_op  [4] = '{6'b011000, 6'b011001, 6'b011100, 6'b100000};
    logic [31:0] st_y   [4] = '{32'h3, 32'h13, 32'h0, 32'h33};
    logic [31:0] st_fl  [4] = '{32'b100, 32'b010, 32'b001, 32'b000};

    initial begin
        int n1, n4;
        // Reset
        tick();
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", {31'b0, in_ready}, 32'd1);

        // ADD with 3 cycles of backpressure
        in_valid = 1'b1; in_ir = mk_ir(6'b100000); in_a = 32'd5; in_b = 32'd7;
        in_pc = 32'h10; in_d = 32'h55;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("add_valid", {31'b0, out_valid}, 32'd1);
            check("add_y", out_y, 32'd12);
            check("add_in_ready", {31'b0, in_ready}, 32'd0);
            check("add_d", out_d, 32'h55);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("add_rdy_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("add_empty", {31'b0, out_valid}, 32'd0);

        // Single instructions from a table
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_ir = mk_ir(tab_op[i]); in_a = tab_a[i]; in_b = tab_b[i];
            tick();
            in_valid = 1'b0;
            check($sformatf("tab%0d_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("tab%0d_y", i), out_y, tab_y[i]);
            tick();
        end

        // MUL on both iteration widths
        out_ready = 1'b0; out_ready4 = 1'b0;
        in_valid = 1'b1; in_valid4 = 1'b1;
        in_ir = mk_ir(6'b100010); in_a = 32'hFFFFFFFD; in_b = 32'd7;
        tick();
        in_valid = 1'b0; in_valid4 = 1'b0;
        n1 = 0; n4 = 0;
        for (int i = 0; i < 100 && (busy || busy4); i++) begin
            if (busy) n1++;
            if (busy4) n4++;
            if (busy) check("mul_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        check("mul1_cycles", n1, 32'd32);
        check("mul4_cycles", n4, 32'd8);
        check("mul1_valid", {31'b0, out_valid}, 32'd1);
        check("mul1_y", out_y, 32'hFFFFFFEB);
        check("mul4_valid", {31'b0, out_valid4}, 32'd1);
        check("mul4_y", out_y4, 32'hFFFFFFEB);
        out_ready = 1'b1; out_ready4 = 1'b1;
        tick();
        check("mul_drain", {31'b0, out_valid}, 32'd0);

        // Illegal opcode
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = 32'h0; in_pc = 32'h100; in_a = 32'd1; in_b = 32'd2;
        tick();
        in_valid = 1'b0;
        check("ill_valid", {31'b0, out_valid}, 32'd1);
        check("ill_ir", out_ir, 32'h77DF0000);
        check("ill_y", out_y, 32'h100);
        check("ill_flags", {29'b0, op_ld_or_ldr, op_st, op_br_or_jmp}, 32'd0);
        out_ready = 1'b1;
        tick();

        // Flush 10 cycles into a MUL
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = mk_ir(6'b100010); in_a = 32'hFFFFFFFD; in_b = 32'd7;
        in_pc = 32'h200;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("fl_mul_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        #1;
        check("fl_mul_comb_ir", out_ir, 32'h83FFF800);
        tick();
        flush = 1'b0;
        #1;
        check("fl_mul_valid", {31'b0, out_valid}, 32'd1);
        check("fl_mul_busy_after", {31'b0, busy}, 32'd0);
        check("fl_mul_ir", out_ir, 32'h83FFF800);
        check("fl_mul_y", out_y, 32'd0);
        check("fl_mul_pc", out_pc, 32'h200);
        out_ready = 1'b1;
        tick();

        // Flush while FULL and departing
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = mk_ir(6'b100000); in_a = 32'd5; in_b = 32'd7;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1; flush = 1'b1;
        #1;
        check("fl_full_valid", {31'b0, out_valid}, 32'd1);
        check("fl_full_ir", out_ir, 32'h83FFF800);
        check("fl_full_y", out_y, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("fl_full_gone", {31'b0, out_valid}, 32'd0);

        // Back-to-back LD/ST/BEQ/ADD stream
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                in_valid = 1'b1; in_ir = mk_ir(st_op[i]);
                in_a = 32'(i * 16 + 1); in_b = 32'd2;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < 4) check($sformatf("str%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
            if (i > 0) begin
                check($sformatf("str%0d_valid", i - 1), {31'b0, out_valid}, 32'd1);
                check($sformatf("str%0d_y", i - 1), out_y, st_y[i - 1]);
                check($sformatf("str%0d_flags", i - 1),
                      {29'b0, op_ld_or_ldr, op_st, op_br_or_jmp}, st_fl[i - 1]);
            end
            tick();
        end
        check("str_empty", {31'b0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
